axi_stream_demux_fifo_n: RTL and testbench

- AXI-Stream 1-to-N demultiplexer with a per-output-channel FIFO of configurable depth.
- Each input beat carries a destination address and is steered into that channel's FIFO.
- Input accepts as long as the addressed FIFO has room, so a stalled output only blocks traffic addressed to it once its FIFO fills.
- Adds tlast passthrough and an optional drop mode for out-of-range addresses.
- Sits between a single stream producer and N independent consumers.

---
 rtl/axi_stream_demux_fifo_n.sv | 143 ++++++++++++++
 tb/tb_axi_stream_demux_fifo_n.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_demux_fifo_n.sv
// AXI-Stream 1-to-N demultiplexer. Each input beat is steered by taddr_i into
// a per-channel first-word-fall-through FIFO, so a stalled consumer only blocks
// traffic addressed to it once its own FIFO is full. Beats addressed beyond
// CH_NUM are either swallowed and counted, or held off, depending on DROP_INVALID.
module axi_stream_demux_fifo_n #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 2,
  parameter int CH_NUM       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_INVALID = 1
) (
  input  logic                                       aclk_i,
  input  logic                                       aresetn_i,
  input  logic [DATA_WIDTH-1:0]                      tdata_i,
  input  logic [ADDR_WIDTH-1:0]                      taddr_i,
  input  logic                                       tlast_i,
  input  logic                                       tvalid_i,
  output logic                                       tready_o,
  output logic [DATA_WIDTH-1:0]                      tdata_o [0:CH_NUM-1],
  output logic [CH_NUM-1:0]                          tlast_o,
  output logic [CH_NUM-1:0]                          tvalid_o,
  input  logic [CH_NUM-1:0]                          tready_i,
  output logic [CH_NUM*($clog2(FIFO_DEPTH)+1)-1:0]   fill_o,
  output logic [15:0]                                drop_cnt_o
);

  localparam int IW = $clog2(FIFO_DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] DEPTH_V  = PW'(FIFO_DEPTH);

  // Each entry is {tlast, tdata}.
  logic [DATA_WIDTH:0] r_mem    [CH_NUM][FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr [CH_NUM];
  logic [PW-1:0]       r_rd_ptr [CH_NUM];
  logic [15:0]         r_drop_cnt;

  logic [PW-1:0]       w_fill   [CH_NUM];
  logic [CH_NUM-1:0]   w_full;
  logic [CH_NUM-1:0]   w_empty;
  logic [CH_NUM-1:0]   w_push;
  logic [CH_NUM-1:0]   w_pop;
  logic                w_addr_ok;
  logic                w_sel_full;
  logic                w_ready;
  logic                w_drop;

  // Per-channel occupancy and full/empty flags derived from the pointer distance.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      w_fill[k]  = r_wr_ptr[k] - r_rd_ptr[k];
      w_full[k]  = (w_fill[k] == DEPTH_V);
      w_empty[k] = (w_fill[k] == PTR_ZERO);
    end
  end

  // Input ready: full flag of the addressed channel, or the drop policy for out-of-range addresses.
  always_comb begin
    w_addr_ok  = (int'(taddr_i) < CH_NUM);
    w_sel_full = 1'b1;
    for (int k = 0; k < CH_NUM; k++) begin
      w_sel_full = (int'(taddr_i) == k) ? w_full[k] : w_sel_full;
    end
    if (!aresetn_i) begin
      w_ready = 1'b0;
    end else if (w_addr_ok) begin
      w_ready = !w_sel_full;
    end else begin
      w_ready = (DROP_INVALID != 0);
    end
  end

  // Push/pop strobes per channel and the drop strobe for accepted invalid beats.
  always_comb begin
    w_push = {CH_NUM{1'b0}};
    w_pop  = {CH_NUM{1'b0}};
    for (int k = 0; k < CH_NUM; k++) begin
      w_push[k] = tvalid_i && w_ready && w_addr_ok && (int'(taddr_i) == k);
      w_pop[k]  = !w_empty[k] && tready_i[k];
    end
    w_drop = tvalid_i && w_ready && !w_addr_ok;
  end

  // Write and read pointers; both may advance in the same cycle, leaving fill unchanged.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int k = 0; k < CH_NUM; k++) begin
        r_wr_ptr[k] <= PTR_ZERO;
        r_rd_ptr[k] <= PTR_ZERO;
      end
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (w_push[k]) begin
          r_wr_ptr[k] <= r_wr_ptr[k] + PTR_ONE;
        end else begin
          r_wr_ptr[k] <= r_wr_ptr[k];
        end
        if (w_pop[k]) begin
          r_rd_ptr[k] <= r_rd_ptr[k] + PTR_ONE;
        end else begin
          r_rd_ptr[k] <= r_rd_ptr[k];
        end
      end
    end
  end

  // Storage write; the payload array is not reset since head data is qualified by valid.
  always_ff @(posedge aclk_i) begin
    for (int k = 0; k < CH_NUM; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wr_ptr[k][IW-1:0]] <= {tlast_i, tdata_i};
      end
    end
  end

  // Saturating counter of discarded out-of-range beats.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  // Output side: head entry of each FIFO, valid when non-empty, tlast qualified by valid.
  always_comb begin
    fill_o = {(CH_NUM*PW){1'b0}};
    for (int k = 0; k < CH_NUM; k++) begin
      tvalid_o[k]          = !w_empty[k];
      tdata_o[k]           = r_mem[k][r_rd_ptr[k][IW-1:0]][DATA_WIDTH-1:0];
      tlast_o[k]           = !w_empty[k] && r_mem[k][r_rd_ptr[k][IW-1:0]][DATA_WIDTH];
      fill_o[k*PW +: PW]   = w_fill[k];
    end
  end

  assign tready_o   = w_ready;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_axi_stream_demux_fifo_n.sv
// Bench for axi_stream_demux_fifo_n: directed stimulus pushes expected beats
// into per-channel queues; an independent monitor pops and compares them
// whenever a channel hands a beat out.
module tb_axi_stream_demux_fifo_n;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [15:0] tdata_i;
  logic [1:0]  taddr_i;
  logic        tlast_i;
  logic        tvalid_a, tvalid_b, tvalid_c;
  logic        tready_a, tready_b, tready_c;
  logic [15:0] tdata_a [0:3];
  logic [15:0] tdata_b [0:2];
  logic [15:0] tdata_c [0:2];
  logic [3:0]  tlast_a, tvalid_oa;
  logic [2:0]  tlast_b, tvalid_ob, tlast_c, tvalid_oc;
  logic [3:0]  tready_i, tready_dir, tready_rnd;
  logic        rnd_rdy;
  logic [11:0] fill_a;
  logic [8:0]  fill_b, fill_c;
  logic [15:0] drop_a, drop_b, drop_c;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb_q [4][$];

  assign tready_i = rnd_rdy ? tready_rnd : tready_dir;

  always #5 clk = ~clk;

  axi_stream_demux_fifo_n #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .CH_NUM(4), .FIFO_DEPTH(4), .DROP_INVALID(1)) dut_a (
    .aclk_i(clk), .aresetn_i(aresetn), .tdata_i(tdata_i), .taddr_i(taddr_i), .tlast_i(tlast_i),
    .tvalid_i(tvalid_a), .tready_o(tready_a), .tdata_o(tdata_a), .tlast_o(tlast_a),
    .tvalid_o(tvalid_oa), .tready_i(tready_i), .fill_o(fill_a), .drop_cnt_o(drop_a));

  axi_stream_demux_fifo_n #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .CH_NUM(3), .FIFO_DEPTH(4), .DROP_INVALID(1)) dut_b (
    .aclk_i(clk), .aresetn_i(aresetn), .tdata_i(tdata_i), .taddr_i(taddr_i), .tlast_i(tlast_i),
    .tvalid_i(tvalid_b), .tready_o(tready_b), .tdata_o(tdata_b), .tlast_o(tlast_b),
    .tvalid_o(tvalid_ob), .tready_i(tready_i[2:0]), .fill_o(fill_b), .drop_cnt_o(drop_b));

  axi_stream_demux_fifo_n #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .CH_NUM(3), .FIFO_DEPTH(4), .DROP_INVALID(0)) dut_c (
    .aclk_i(clk), .aresetn_i(aresetn), .tdata_i(tdata_i), .taddr_i(taddr_i), .tlast_i(tlast_i),
    .tvalid_i(tvalid_c), .tready_o(tready_c), .tdata_o(tdata_c), .tlast_o(tlast_c),
    .tvalid_o(tvalid_oc), .tready_i(tready_i[2:0]), .fill_o(fill_c), .drop_cnt_o(drop_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] fill_of(input int k);
    return fill_a[k*3 +: 3];
  endfunction

  // Monitor: every beat handed out by the main DUT must match the scoreboard head.
  always @(negedge clk) begin
    if (aresetn) begin
      for (int k = 0; k < 4; k++) begin
        if (tvalid_oa[k] && tready_i[k]) begin
          checks++;
          if (sb_q[k].size() == 0) begin
            errors++;
            $display("FAIL out_unexpected ch%0d actual=%0h expected=none", k, {tlast_a[k], tdata_a[k]});
          end else begin
            logic [16:0] e;
            e = sb_q[k].pop_front();
            if ({tlast_a[k], tdata_a[k]} !== e) begin
              errors++;
              $display("FAIL out_data ch%0d actual=%0h expected=%0h", k, {tlast_a[k], tdata_a[k]}, e);
            end
          end
        end
      end
    end
  end

  // Random consumer readiness used by the mixed-traffic phase.
  always @(posedge clk) begin
    #1;
    tready_rnd = 4'($urandom);
  end

  // Present a beat to the main DUT and wait (bounded) until it is accepted.
  task automatic send(input logic [1:0] a, input logic [15:0] d, input logic l);
    bit done;
    done = 1'b0;
    taddr_i = a; tdata_i = d; tlast_i = l; tvalid_a = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (tready_a) begin
        sb_q[a].push_back({l, d});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    tvalid_a = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sb_empty(input string name);
    chk(name, sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size(), 32'd0);
  endtask

  initial begin
    aresetn = 1'b0; tdata_i = 16'h0; taddr_i = 2'd0; tlast_i = 1'b0;
    tvalid_a = 1'b0; tvalid_b = 1'b0; tvalid_c = 1'b0;
    tready_dir = 4'h0; rnd_rdy = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", tvalid_oa, 4'h0);
    chk("rst_fill", fill_a, 12'h0);
    chk("rst_tready", tready_a, 1'b0);
    chk("rst_tlast", tlast_a, 4'h0);
    chk("rst_drop", drop_a, 16'h0);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;

    // 1: single beat, visible the cycle after acceptance, then popped
    send(2'd2, 16'hA5A5, 1'b1);
    @(negedge clk);
    chk("t1_tvalid", tvalid_oa, 4'b0100);
    chk("t1_tdata", tdata_a[2], 16'hA5A5);
    chk("t1_tlast", tlast_a[2], 1'b1);
    chk("t1_fill", fill_of(2), 3'd1);
    @(posedge clk); #1; tready_dir = 4'b0100;
    @(posedge clk); #1; tready_dir = 4'b0000;
    @(negedge clk);
    chk("t1_tvalid_after_pop", tvalid_oa, 4'b0000);
    @(posedge clk); #1;

    // 2: fill channel 1, fifth beat held off, then drain in order
    for (int i = 1; i <= 4; i++) send(2'd1, 16'(i), 1'b0);
    taddr_i = 2'd1; tdata_i = 16'd5; tlast_i = 1'b1; tvalid_a = 1'b1;
    @(negedge clk);
    chk("t2_tready_full", tready_a, 1'b0);
    chk("t2_fill_full", fill_of(1), 3'd4);
    @(posedge clk); #1; tready_dir = 4'b0010;
    fork
      send(2'd1, 16'd5, 1'b1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t2_tvalid_held", tvalid_oa[1], 1'b1);
        end
      end
    join
    cycles(4);
    tready_dir = 4'b0000;
    chk("t2_fill_drained", fill_of(1), 3'd0);
    sb_empty("t2_sb_empty");

    // 3: channel 0 full and stalled does not block channel 3
    for (int i = 0; i < 4; i++) send(2'd0, 16'h20 + 16'(i), 1'b0);
    tready_dir = 4'b1000;
    taddr_i = 2'd3; tdata_i = 16'h30; tlast_i = 1'b0; tvalid_a = 1'b1;
    @(negedge clk);
    chk("t3_tready_ch3", tready_a, 1'b1);
    @(posedge clk); #1; tvalid_a = 1'b0;
    sb_q[3].push_back({1'b0, 16'h30});
    send(2'd3, 16'h31, 1'b1);
    cycles(3);
    @(negedge clk);
    chk("t3_fill_ch0", fill_of(0), 3'd4);
    chk("t3_tvalid", tvalid_oa, 4'b0001);
    chk("t3_sb_ch3", sb_q[3].size(), 32'd0);
    @(posedge clk); #1; tready_dir = 4'b0001;
    cycles(6);
    tready_dir = 4'b0000;
    sb_empty("t3_sb_empty");

    // 4: simultaneous push and pop at fill 2
    send(2'd1, 16'h40, 1'b0);
    send(2'd1, 16'h41, 1'b0);
    tready_dir = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      taddr_i = 2'd1; tdata_i = 16'h42 + 16'(i); tlast_i = 1'(i & 1); tvalid_a = 1'b1;
      @(negedge clk);
      chk("t4_fill", fill_of(1), 3'd2);
      if (tready_a) sb_q[1].push_back({tlast_i, tdata_i});
      else chk("t4_tready", tready_a, 1'b1);
      @(posedge clk); #1;
    end
    tvalid_a = 1'b0;
    cycles(3);
    tready_dir = 4'b0000;
    sb_empty("t4_sb_empty");

    // 5: out-of-range address with drop enabled and disabled
    taddr_i = 2'd3; tdata_i = 16'hDEAD; tlast_i = 1'b0; tvalid_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_tready_drop", tready_b, 1'b1);
      @(posedge clk); #1;
    end
    tvalid_b = 1'b0;
    @(negedge clk);
    chk("t5_drop_cnt", drop_b, 16'd3);
    chk("t5_tvalid_drop", tvalid_ob, 3'b000);
    chk("t5_fill_drop", fill_b, 9'd0);
    @(posedge clk); #1; tvalid_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_tready_hold", tready_c, 1'b0);
      @(posedge clk); #1;
    end
    tvalid_c = 1'b0;
    @(negedge clk);
    chk("t5_drop_hold", drop_c, 16'd0);
    chk("t5_tvalid_hold", tvalid_oc, 3'b000);
    chk("t5_drop_main", drop_a, 16'd0);
    @(posedge clk); #1;

    // 6: random traffic and consumers, reset pulsed mid-stream
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) begin
        aresetn = 1'b0;
        for (int k = 0; k < 4; k++) sb_q[k].delete();
        taddr_i = 2'd0;
        @(negedge clk);
        chk("t6_rst_tvalid", tvalid_oa, 4'h0);
        chk("t6_rst_fill", fill_a, 12'h0);
        chk("t6_rst_tready", tready_a, 1'b0);
        @(negedge clk); aresetn = 1'b1;
        @(posedge clk); #1;
      end
      send(2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom));
    end
    rnd_rdy = 1'b0;
    tready_dir = 4'hF;
    cycles(10);
    @(negedge clk);
    chk("t6_tvalid_end", tvalid_oa, 4'h0);
    sb_empty("t6_sb_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
